mac_requant_packer: RTL and testbench

Downstream stage of `plexed_swift_piped_mac`. Consumes the MAC's signed 32-bit accumulator results over AXI-Stream and requantizes each one to int8: fixed-point scale, rounding right shift, optional ReLU, zero-point add, saturation. It packs four consecutive int8 results little-endian into one 32-bit output word, so the activation memory can store them directly.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/requant_lane.sv | 80 ++++++++
 rtl/mac_requant_packer.sv | 96 +++++++++
 tb/tb_mac_requant_packer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths, the int8 lane type and the saturating narrow
// used by the requantizer and the output packer.
package mac_pkg;

    localparam int ACC_W  = 32;
    localparam int OUT_W  = 8;
    localparam int LANES  = 4;
    localparam int PROD_W = 49;
    // Rounded, shifted value plus zero point needs two extra bits.
    localparam int SAT_W  = PROD_W + 2;

    typedef logic signed [OUT_W-1:0] int8_t;

    // Clamp a wide signed value to [-128, 127].
    function automatic int8_t sat8(input logic signed [SAT_W-1:0] x);
        int8_t y;
        if (!x[SAT_W-1] && (|x[SAT_W-2:OUT_W-1])) begin
            y = 8'h7f;
        end else if (x[SAT_W-1] && !(&x[SAT_W-2:OUT_W-1])) begin
            y = 8'h80;
        end else begin
            y = x[OUT_W-1:0];
        end
        return y;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Two-stage requantizer: scale multiply, then round-shift, ReLU,
// zero-point add and int8 saturation.
// Ports: clk/rst_n, en (pipeline advance), acc/acc_valid/acc_last in,
// scale/shift/zp/relu config, q/q_valid/q_last out.
module requant_lane
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] acc,
    input  logic             acc_valid,
    input  logic             acc_last,
    input  logic [15:0]      scale,
    input  logic [4:0]       shift,
    input  int8_t            zp,
    input  logic             relu,
    output int8_t            q,
    output logic             q_valid,
    output logic             q_last
);

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] s1_prod;
    logic                     s1_valid;
    logic                     s1_last;

    logic signed [PROD_W:0]   rnd;
    logic signed [PROD_W:0]   sum;
    logic signed [PROD_W:0]   r;
    logic signed [SAT_W-1:0]  t;

    // Scale is unsigned, so it is zero-extended before the signed multiply.
    assign prod = $signed({{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc})
                * $signed({{(PROD_W-16){1'b0}}, scale});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else if (en) begin
            s1_valid <= acc_valid;
            s1_last  <= acc_valid & acc_last;
            if (acc_valid) begin
                s1_prod <= prod;
            end
        end
    end

    // Adding half an LSB before the arithmetic shift rounds half up.
    always_comb begin
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = {{PROD_W{1'b0}}, 1'b1} << (shift - 5'd1);
        end
        sum = $signed({s1_prod[PROD_W-1], s1_prod}) + rnd;
        r   = sum >>> shift;
        if (relu && r[PROD_W]) begin
            r = '0;
        end
        t = $signed({r[PROD_W], r})
          + $signed({{(SAT_W-OUT_W){zp[OUT_W-1]}}, zp});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_last  <= 1'b0;
            q       <= '0;
        end else if (en) begin
            q_valid <= s1_valid;
            q_last  <= s1_valid & s1_last;
            if (s1_valid) begin
                q <= sat8(t);
            end
        end
    end

endmodule

// File: rtl/mac_requant_packer.sv
// Requantizes signed 32-bit accumulators to int8 and packs four
// results little-endian per 32-bit AXI-Stream output word.
// Ports: ACLK/ARESETN, SD_AXIS_* accumulator input stream,
// CFG_* quasi-static requant config, MO_AXIS_* packed output stream.
module mac_requant_packer
    import mac_pkg::*;
(
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [ACC_W-1:0] SD_AXIS_TDATA,
    input  logic             SD_AXIS_TVALID,
    output logic             SD_AXIS_TREADY,
    input  logic             SD_AXIS_TLAST,
    input  logic [15:0]      CFG_SCALE,
    input  logic [4:0]       CFG_SHIFT,
    input  logic [OUT_W-1:0] CFG_ZP,
    input  logic             CFG_RELU,
    output logic [31:0]      MO_AXIS_TDATA,
    output logic [LANES-1:0] MO_AXIS_TKEEP,
    output logic             MO_AXIS_TVALID,
    input  logic             MO_AXIS_TREADY,
    output logic             MO_AXIS_TLAST
);

    logic                              stall;
    logic                              fire;
    logic                              load;
    int8_t                             q;
    logic                              q_valid;
    logic                              q_last;
    logic [1:0]                        lane_cnt;
    logic [LANES-1:0][OUT_W-1:0]       lanes;
    logic [LANES-1:0][OUT_W-1:0]       word;
    logic [LANES-1:0]                  keep;

    assign stall = MO_AXIS_TVALID & ~MO_AXIS_TREADY;
    // Gated by reset so the input side reads not-ready while held in reset.
    assign SD_AXIS_TREADY = ~stall & ARESETN;
    assign fire = SD_AXIS_TVALID & SD_AXIS_TREADY;
    assign load = ~stall & q_valid & ((lane_cnt == 2'd3) | q_last);

    requant_lane u_lane (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .en        (~stall),
        .acc       (SD_AXIS_TDATA),
        .acc_valid (fire),
        .acc_last  (SD_AXIS_TLAST),
        .scale     (CFG_SCALE),
        .shift     (CFG_SHIFT),
        .zp        (CFG_ZP),
        .relu      (CFG_RELU),
        .q         (q),
        .q_valid   (q_valid),
        .q_last    (q_last)
    );

    // Word as it would look with the incoming byte merged in.
    always_comb begin
        word           = lanes;
        word[lane_cnt] = q;
        for (int i = 0; i < LANES; i++) begin
            keep[i] = (i <= int'(lane_cnt));
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lane_cnt       <= 2'd0;
            lanes          <= '0;
            MO_AXIS_TDATA  <= '0;
            MO_AXIS_TKEEP  <= '0;
            MO_AXIS_TVALID <= 1'b0;
            MO_AXIS_TLAST  <= 1'b0;
        end else begin
            if (!stall && q_valid) begin
                if (load) begin
                    lanes    <= '0;
                    lane_cnt <= 2'd0;
                end else begin
                    lanes    <= word;
                    lane_cnt <= lane_cnt + 2'd1;
                end
            end
            if (load) begin
                MO_AXIS_TDATA  <= word;
                MO_AXIS_TKEEP  <= keep;
                MO_AXIS_TLAST  <= q_last;
                MO_AXIS_TVALID <= 1'b1;
            end else if (MO_AXIS_TREADY) begin
                MO_AXIS_TVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_requant_packer.sv
// Directed bench for mac_requant_packer: requant math, packing,
// flush, backpressure and mid-word reset.
module tb_mac_requant_packer;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] SD_AXIS_TDATA;
    logic        SD_AXIS_TVALID;
    logic        SD_AXIS_TREADY;
    logic        SD_AXIS_TLAST;
    logic [15:0] CFG_SCALE;
    logic [4:0]  CFG_SHIFT;
    logic [7:0]  CFG_ZP;
    logic        CFG_RELU;
    logic [31:0] MO_AXIS_TDATA;
    logic [3:0]  MO_AXIS_TKEEP;
    logic        MO_AXIS_TVALID;
    logic        MO_AXIS_TREADY;
    logic        MO_AXIS_TLAST;

    int tests = 0;
    int fails = 0;

    mac_requant_packer dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .SD_AXIS_TDATA  (SD_AXIS_TDATA),
        .SD_AXIS_TVALID (SD_AXIS_TVALID),
        .SD_AXIS_TREADY (SD_AXIS_TREADY),
        .SD_AXIS_TLAST  (SD_AXIS_TLAST),
        .CFG_SCALE      (CFG_SCALE),
        .CFG_SHIFT      (CFG_SHIFT),
        .CFG_ZP         (CFG_ZP),
        .CFG_RELU       (CFG_RELU),
        .MO_AXIS_TDATA  (MO_AXIS_TDATA),
        .MO_AXIS_TKEEP  (MO_AXIS_TKEEP),
        .MO_AXIS_TVALID (MO_AXIS_TVALID),
        .MO_AXIS_TREADY (MO_AXIS_TREADY),
        .MO_AXIS_TLAST  (MO_AXIS_TLAST)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until the handshake completes.
    // Returns 1 time unit after the accepting edge.
    task automatic beat(input logic [31:0] d, input logic last);
        bit ok;
        ok             = 1'b0;
        SD_AXIS_TDATA  = d;
        SD_AXIS_TVALID = 1'b1;
        SD_AXIS_TLAST  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            ok = SD_AXIS_TREADY;
            @(posedge ACLK);
            #1;
        end
        tests++;
        assert (ok) else begin
            fails++;
            $error("FAIL beat_accept got=0 exp=1 data=%0h", d);
        end
    endtask

    task automatic idle();
        SD_AXIS_TVALID = 1'b0;
        SD_AXIS_TLAST  = 1'b0;
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETN        = 1'b0;
        SD_AXIS_TDATA  = '0;
        SD_AXIS_TVALID = 1'b0;
        SD_AXIS_TLAST  = 1'b0;
        CFG_SCALE      = 16'd1;
        CFG_SHIFT      = 5'd0;
        CFG_ZP         = 8'd0;
        CFG_RELU       = 1'b0;
        MO_AXIS_TREADY = 1'b1;

        // Reset state
        #2;
        chk("rst_tvalid", 32'(MO_AXIS_TVALID), 32'd0);
        chk("rst_tdata", MO_AXIS_TDATA, 32'd0);
        chk("rst_tkeep", 32'(MO_AXIS_TKEEP), 32'd0);
        chk("rst_tlast", 32'(MO_AXIS_TLAST), 32'd0);
        chk("rst_sready", 32'(SD_AXIS_TREADY), 32'd0);
        @(posedge ACLK);
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        #1;
        chk("rel_sready", 32'(SD_AXIS_TREADY), 32'd1);

        // 1. Identity packing, latency 2 after the 4th beat
        beat(32'd5, 1'b0);
        beat(-32'sd3, 1'b0);
        beat(32'd200, 1'b0);
        beat(-32'sd300, 1'b1);
        idle();
        chk("t1_lat0", 32'(MO_AXIS_TVALID), 32'd0);
        step();
        chk("t1_lat1", 32'(MO_AXIS_TVALID), 32'd0);
        step();
        chk("t1_valid", 32'(MO_AXIS_TVALID), 32'd1);
        chk("t1_data", MO_AXIS_TDATA, 32'h807FFD05);
        chk("t1_keep", 32'(MO_AXIS_TKEEP), 32'hF);
        chk("t1_last", 32'(MO_AXIS_TLAST), 32'd1);
        step();
        chk("t1_clear", 32'(MO_AXIS_TVALID), 32'd0);

        // 2. Rounding
        CFG_SCALE = 16'd3;
        CFG_SHIFT = 5'd2;
        beat(32'd7, 1'b0);
        beat(-32'sd7, 1'b0);
        beat(32'd6, 1'b0);
        beat(-32'sd6, 1'b0);
        idle();
        step();
        step();
        chk("t2_valid", 32'(MO_AXIS_TVALID), 32'd1);
        chk("t2_data", MO_AXIS_TDATA, 32'hFC05FB05);
        chk("t2_last", 32'(MO_AXIS_TLAST), 32'd0);
        step();
        chk("t2_clear", 32'(MO_AXIS_TVALID), 32'd0);

        // 3. ReLU and zero point
        CFG_SCALE = 16'd1;
        CFG_SHIFT = 5'd0;
        CFG_ZP    = 8'd10;
        CFG_RELU  = 1'b1;
        beat(-32'sd50, 1'b0);
        beat(32'd120, 1'b0);
        beat(32'd3, 1'b0);
        beat(-32'sd1, 1'b0);
        idle();
        step();
        step();
        chk("t3_valid", 32'(MO_AXIS_TVALID), 32'd1);
        chk("t3_data", MO_AXIS_TDATA, 32'h0A0D7F0A);
        step();
        CFG_ZP   = 8'd0;
        CFG_RELU = 1'b0;

        // 4. Partial flush, then packing restarts at lane 0
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b1);
        idle();
        step();
        step();
        chk("t4_valid", 32'(MO_AXIS_TVALID), 32'd1);
        chk("t4_data", MO_AXIS_TDATA, 32'h00000201);
        chk("t4_keep", 32'(MO_AXIS_TKEEP), 32'h3);
        chk("t4_last", 32'(MO_AXIS_TLAST), 32'd1);
        step();
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h33, 1'b0);
        beat(32'h44, 1'b1);
        idle();
        step();
        step();
        chk("t4_full_data", MO_AXIS_TDATA, 32'h44332211);
        chk("t4_full_keep", 32'(MO_AXIS_TKEEP), 32'hF);
        step();
        // TLAST on lane 0
        beat(32'h07, 1'b1);
        idle();
        step();
        step();
        chk("t4_l0_valid", 32'(MO_AXIS_TVALID), 32'd1);
        chk("t4_l0_data", MO_AXIS_TDATA, 32'h00000007);
        chk("t4_l0_keep", 32'(MO_AXIS_TKEEP), 32'h1);
        chk("t4_l0_last", 32'(MO_AXIS_TLAST), 32'd1);
        step();

        // 5. Backpressure: first word appears with beat 6's edge
        for (int v = 1; v <= 6; v++) begin
            beat(32'(v), 1'b0);
        end
        MO_AXIS_TREADY = 1'b0;
        SD_AXIS_TDATA  = 32'd7;
        SD_AXIS_TVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_sready_low", 32'(SD_AXIS_TREADY), 32'd0);
            chk("t5_hold_valid", 32'(MO_AXIS_TVALID), 32'd1);
            chk("t5_hold_data", MO_AXIS_TDATA, 32'h04030201);
            chk("t5_hold_keep", 32'(MO_AXIS_TKEEP), 32'hF);
            @(posedge ACLK);
        end
        #1 MO_AXIS_TREADY = 1'b1;
        beat(32'd7, 1'b0);
        chk("t5_consumed", 32'(MO_AXIS_TVALID), 32'd0);
        beat(32'd8, 1'b0);
        idle();
        chk("t5_gap0", 32'(MO_AXIS_TVALID), 32'd0);
        step();
        chk("t5_gap1", 32'(MO_AXIS_TVALID), 32'd0);
        step();
        chk("t5_w2_valid", 32'(MO_AXIS_TVALID), 32'd1);
        chk("t5_w2_data", MO_AXIS_TDATA, 32'h08070605);
        step();
        chk("t5_no_dup", 32'(MO_AXIS_TVALID), 32'd0);

        // 6. Reset mid-word discards the partial word
        beat(32'h21, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h23, 1'b0);
        idle();
        step();
        step();
        step();
        ARESETN = 1'b0;
        #1;
        chk("t6_tvalid", 32'(MO_AXIS_TVALID), 32'd0);
        chk("t6_tdata", MO_AXIS_TDATA, 32'd0);
        chk("t6_tkeep", 32'(MO_AXIS_TKEEP), 32'd0);
        chk("t6_tlast", 32'(MO_AXIS_TLAST), 32'd0);
        chk("t6_sready", 32'(SD_AXIS_TREADY), 32'd0);
        #1 ARESETN = 1'b1;
        #1;
        chk("t6_rel_sready", 32'(SD_AXIS_TREADY), 32'd1);
        for (int i = 0; i < 4; i++) begin
            beat(32'd9, 1'b0);
        end
        idle();
        step();
        step();
        chk("t6_valid", 32'(MO_AXIS_TVALID), 32'd1);
        chk("t6_data", MO_AXIS_TDATA, 32'h09090909);
        chk("t6_keep", 32'(MO_AXIS_TKEEP), 32'hF);
        step();
        chk("t6_single", 32'(MO_AXIS_TVALID), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
